// File: rtl/rf_dbg_if.sv
// Debug-engine bus: command handshake, register-file read/write ports, dump and load streams.
// The engine is the slave; the debug host plus the register file sit on the master side.
interface rf_dbg_if #(
   parameter int REG_W  = 5,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_op;
   logic              cmd_ready;

   logic [REG_W-1:0]  rf_a1;
   logic [DATA_W-1:0] rf_rd1;
   logic [REG_W-1:0]  rf_a3;
   logic [DATA_W-1:0] rf_wd;
   logic              rf_we;

   logic              dout_valid;
   logic              dout_ready;
   logic [DATA_W-1:0] dout_data;
   logic [REG_W-1:0]  dout_idx;

   logic              din_valid;
   logic              din_ready;
   logic [DATA_W-1:0] din_data;

   logic              busy;
   logic              done;

   modport master (
      output cmd_valid, cmd_op, rf_rd1, dout_ready, din_valid, din_data,
      input  cmd_ready, rf_a1, rf_a3, rf_wd, rf_we, dout_valid, dout_data, dout_idx,
             din_ready, busy, done
   );

   modport slave (
      input  cmd_valid, cmd_op, rf_rd1, dout_ready, din_valid, din_data,
      output cmd_ready, rf_a1, rf_a3, rf_wd, rf_we, dout_valid, dout_data, dout_idx,
             din_ready, busy, done
   );
endinterface

// File: rtl/rf_dbg_engine.sv
// Register-file debug engine: streams every register out (dump) or writes registers 1..REG_S-1
// from an input stream (load) while the core is held off the RF ports via busy.
module rf_dbg_engine #(
   parameter int REG_W  = 5,
   parameter int REG_S  = 32,
   parameter int DATA_W = 32
) (
   input  logic    clk,
   input  logic    rst_n,
   rf_dbg_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      DUMP,
      DRAIN,
      LOAD,
      FIN
   } state_t;

   localparam logic [REG_W:0] LAST_IDX = (REG_W+1)'(REG_S - 1);
   localparam logic [REG_W:0] IDX_ONE  = (REG_W+1)'(1);

   state_t         state;
   logic [REG_W:0] idx;
   logic           dump_adv;
   logic           load_adv;

   // A dump beat is captured whenever the output slot is empty or being drained this cycle.
   assign dump_adv = (state == DUMP) && (!bus.dout_valid || bus.dout_ready);
   assign load_adv = (state == LOAD) && bus.din_valid;

   assign bus.cmd_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.rf_a1     = (state == DUMP) ? idx[REG_W-1:0] : '0;
   assign bus.din_ready = (state == LOAD);
   assign bus.rf_we     = load_adv;
   assign bus.rf_a3     = (state == LOAD) ? idx[REG_W-1:0] : '0;
   assign bus.rf_wd     = bus.din_data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         idx            <= '0;
         bus.dout_valid <= 1'b0;
         bus.dout_data  <= '0;
         bus.dout_idx   <= '0;
         bus.done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  if (bus.cmd_op) begin
                     // Register 0 is hard-wired, so a load starts at 1.
                     state <= LOAD;
                     idx   <= IDX_ONE;
                  end else begin
                     state <= DUMP;
                     idx   <= '0;
                  end
               end
            end

            DUMP: begin
               if (dump_adv) begin
                  bus.dout_data  <= bus.rf_rd1;
                  bus.dout_idx   <= idx[REG_W-1:0];
                  bus.dout_valid <= 1'b1;
                  idx            <= idx + IDX_ONE;
                  if (idx == LAST_IDX) begin
                     state <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (bus.dout_ready) begin
                  bus.dout_valid <= 1'b0;
                  bus.done       <= 1'b1;
                  state          <= FIN;
               end
            end

            LOAD: begin
               if (load_adv) begin
                  idx <= idx + IDX_ONE;
                  if (idx == LAST_IDX) begin
                     bus.done <= 1'b1;
                     state    <= FIN;
                  end
               end
            end

            FIN: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
